// File: rtl/fetch_pkg.sv
// Shared types, defaults and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned INST_W_DEF = 16;
  localparam int unsigned IVT_CALC_W = 64;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_RET,
    SRC_INT,
    SRC_RST
  } redirect_src_e;

  // Vector address; the caller truncates to its PC width so the sum wraps.
  function automatic logic [IVT_CALC_W-1:0] ivt_target(
    input logic [IVT_CALC_W-1:0] base,
    input logic [IVT_CALC_W-1:0] idx,
    input logic [IVT_CALC_W-1:0] stride
  );
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO holding fetched words with their PC tags; flush empties it in one cycle.
module fetch_queue #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop frees a slot in the same cycle, so push-while-full is legal alongside it.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: prioritised PC redirects, 1-cycle imem request issue and a PC-tagged
// fetch queue feeding decode over valid/ready.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      PC_W        = PC_W_DEF,
  parameter int unsigned      INST_W      = INST_W_DEF,
  parameter int unsigned      DEPTH       = 4,
  parameter int unsigned      IVT_ENTRIES = 8,
  parameter int unsigned      IVT_STRIDE  = 2,
  parameter logic [PC_W-1:0]  RESET_VEC   = '0,
  parameter int unsigned      RET_MASK    = 4,
  localparam int unsigned     IDX_W       = $clog2(IVT_ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hold,
  input  logic              int_req,
  input  logic [IDX_W-1:0]  int_index,
  input  logic [PC_W-1:0]   ivt_base,
  input  logic              ret_valid,
  input  logic [PC_W-1:0]   ret_pc,
  input  logic              br_valid,
  input  logic [PC_W-1:0]   br_target,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  output logic              redirect_taken
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam int unsigned Q_W   = INST_W + PC_W;

  redirect_src_e    src;
  logic [PC_W-1:0]  fetch_pc;
  logic [PC_W-1:0]  fetch_pc_nxt;
  logic [PC_W-1:0]  rsp_pc;
  logic [PC_W-1:0]  int_tgt;
  logic [PC_W-1:0]  ret_tgt;
  logic             rsp_valid;
  logic             redirect;
  logic             kill_rsp;
  logic             issue;
  logic             push;
  logic             pop;
  logic             redirect_taken_q;
  logic [CNT_W-1:0] q_count;
  logic [Q_W-1:0]   q_head;
  logic [OCC_W-1:0] occupancy;

  assign int_tgt = PC_W'(ivt_target(IVT_CALC_W'(ivt_base), IVT_CALC_W'(int_index),
                                    IVT_CALC_W'(IVT_STRIDE)));
  assign ret_tgt = ret_pc & ({PC_W{1'b1}} >> RET_MASK);

  // Redirect source select, highest priority first.
  always_comb begin
    src = SRC_SEQ;
    if (reset)          src = SRC_RST;
    else if (int_req)   src = SRC_INT;
    else if (ret_valid) src = SRC_RET;
    else if (br_valid)  src = SRC_BR;
  end

  assign redirect  = (src == SRC_INT) || (src == SRC_RET) || (src == SRC_BR);
  // A word landing this cycle is already counted against the queue via rsp_valid.
  assign occupancy = OCC_W'(q_count) + OCC_W'(rsp_valid);
  assign issue     = (src == SRC_SEQ) && !hold && (occupancy < OCC_W'(DEPTH));

  always_comb begin
    fetch_pc_nxt = fetch_pc;
    case (src)
      SRC_RST: fetch_pc_nxt = RESET_VEC;
      SRC_INT: fetch_pc_nxt = int_tgt;
      SRC_RET: fetch_pc_nxt = ret_tgt;
      SRC_BR:  fetch_pc_nxt = br_target;
      SRC_SEQ: if (issue) fetch_pc_nxt = fetch_pc + PC_W'(1);
      default: fetch_pc_nxt = fetch_pc;
    endcase
  end

  always_ff @(posedge clk) begin
    fetch_pc <= fetch_pc_nxt;
    if (reset) begin
      rsp_valid        <= 1'b0;
      redirect_taken_q <= 1'b0;
    end else begin
      rsp_valid        <= issue;
      redirect_taken_q <= redirect;
    end
    if (issue) rsp_pc <= fetch_pc;
  end

  // Requests are suppressed on redirect, so the only stale word is the one landing now.
  assign kill_rsp = redirect;
  assign push     = rsp_valid && !kill_rsp;

  fetch_queue #(
    .WIDTH (Q_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data ({imem_rdata, rsp_pc}),
    .pop       (pop),
    .count     (q_count),
    .head_data (q_head)
  );

  assign imem_req       = issue;
  assign imem_addr      = fetch_pc;
  assign inst_valid     = !reset && (q_count != '0);
  assign inst_data      = q_head[PC_W +: INST_W];
  assign inst_pc        = q_head[PC_W-1:0];
  assign pop            = inst_valid && inst_ready;
  assign redirect_taken = redirect_taken_q && !reset;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: expected decode stream held in a scoreboard queue.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        int_req;
  logic [2:0]  int_index;
  logic [31:0] ivt_base;
  logic        ret_valid;
  logic [31:0] ret_pc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect_taken;

  int checks   = 0;
  int failures = 0;
  int reqs     = 0;
  logic [31:0] exp_q[$];

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .hold           (hold),
    .int_req        (int_req),
    .int_index      (int_index),
    .ivt_base       (ivt_base),
    .ret_valid      (ret_valid),
    .ret_pc         (ret_pc),
    .br_valid       (br_valid),
    .br_target      (br_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .redirect_taken (redirect_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: data = low address bits, valid the cycle after the request.
  always @(posedge clk) imem_rdata <= imem_req ? imem_addr[15:0] : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input logic [31:0] first, input int n);
    logic [31:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(v);
      v = v + 32'd1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    exp_q.delete();
    cyc();
    reset = 1'b0;
    reqs = 0;
  endtask

  // Scoreboard: every accepted head must match the next expected PC.
  always @(negedge clk) begin
    if (imem_req) reqs++;
    if (inst_valid && inst_ready) begin
      check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("inst_pc", inst_pc, e);
        check("inst_data", 32'(inst_data), 32'(e[15:0]));
      end
    end
  end

  initial begin
    reset = 1'b1; hold = 1'b0; int_req = 1'b0; int_index = '0; ivt_base = '0;
    ret_valid = 1'b0; ret_pc = '0; br_valid = 1'b0; br_target = '0; inst_ready = 1'b1;

    // Reset state, then streaming with inst_ready high, then hold.
    cyc(); cyc();
    @(negedge clk);
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_redirect_taken", 32'(redirect_taken), 32'd0);
    push_range(32'd0, 10);
    cyc(); reset = 1'b0;
    @(negedge clk);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'd0);
    cyc(); @(negedge clk);
    check("lat_c1_valid", 32'(inst_valid), 32'd0);
    cyc(); @(negedge clk);
    check("lat_c2_valid", 32'(inst_valid), 32'd1);
    repeat (8) cyc();
    hold = 1'b1;
    @(negedge clk);
    check("hold_no_req", 32'(imem_req), 32'd0);
    repeat (3) cyc();
    @(negedge clk);
    check("hold_drained_valid", 32'(inst_valid), 32'd0);
    check("t1_drained", 32'(exp_q.size()), 32'd0);
    hold = 1'b0;

    // Back-pressure: queue fills to DEPTH and stops requesting.
    inst_ready = 1'b0;
    apply_reset();
    repeat (9) cyc();
    @(negedge clk);
    check("bp_valid", 32'(inst_valid), 32'd1);
    check("bp_head_pc", inst_pc, 32'd0);
    check("bp_no_req", 32'(imem_req), 32'd0);
    check("bp_req_count", 32'(reqs), 32'd4);
    push_range(32'd0, 5);
    cyc(); inst_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    cyc(); inst_ready = 1'b0;
    check("t2_drained", 32'(exp_q.size()), 32'd0);

    // Branch with three queued words and one in flight.
    apply_reset();
    repeat (4) cyc();
    br_valid = 1'b1; br_target = 32'h100;
    @(negedge clk);
    check("br_cycle_no_req", 32'(imem_req), 32'd0);
    check("br_cycle_valid", 32'(inst_valid), 32'd1);
    cyc(); br_valid = 1'b0; inst_ready = 1'b1;
    push_range(32'h100, 4);
    @(negedge clk);
    check("br_flushed", 32'(inst_valid), 32'd0);
    check("br_addr", imem_addr, 32'h100);
    check("br_req", 32'(imem_req), 32'd1);
    check("br_taken", 32'(redirect_taken), 32'd1);
    cyc(); @(negedge clk);
    check("br_stale_dropped", 32'(inst_valid), 32'd0);
    repeat (4) cyc();
    @(negedge clk);
    cyc(); inst_ready = 1'b0;
    check("t3_drained", 32'(exp_q.size()), 32'd0);

    // Priority: interrupt beats return and branch; then return alone with masked flags.
    int_req = 1'b1; int_index = 3'd5; ivt_base = 32'h20;
    ret_valid = 1'b1; ret_pc = 32'hF000_1234;
    br_valid = 1'b1; br_target = 32'h100;
    @(negedge clk);
    check("int_cycle_no_req", 32'(imem_req), 32'd0);
    cyc(); int_req = 1'b0; br_valid = 1'b0;
    @(negedge clk);
    check("int_addr", imem_addr, 32'h2A);
    check("int_taken", 32'(redirect_taken), 32'd1);
    check("ret_cycle_no_req", 32'(imem_req), 32'd0);
    cyc(); ret_valid = 1'b0; inst_ready = 1'b1;
    push_range(32'h1234, 3);
    @(negedge clk);
    check("ret_addr", imem_addr, 32'h0000_1234);
    check("ret_taken", 32'(redirect_taken), 32'd1);
    check("ret_req", 32'(imem_req), 32'd1);
    cyc(); @(negedge clk);
    check("taken_clears", 32'(redirect_taken), 32'd0);
    repeat (3) cyc();
    @(negedge clk);
    cyc(); inst_ready = 1'b0;
    check("t4_drained", 32'(exp_q.size()), 32'd0);

    // PC wrap from all-ones to zero.
    br_valid = 1'b1; br_target = 32'hFFFF_FFFE;
    cyc(); br_valid = 1'b0; inst_ready = 1'b1;
    exp_q.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF);
    push_range(32'd0, 2);
    @(negedge clk);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFE);
    cyc(); @(negedge clk);
    check("wrap_addr1", imem_addr, 32'hFFFF_FFFF);
    cyc(); @(negedge clk);
    check("wrap_addr2", imem_addr, 32'd0);
    check("wrap_req", 32'(imem_req), 32'd1);
    repeat (3) cyc();
    @(negedge clk);
    cyc(); inst_ready = 1'b0;
    check("t5_drained", 32'(exp_q.size()), 32'd0);

    // Reset mid-stream with a full queue, colliding with a branch.
    repeat (5) cyc();
    @(negedge clk);
    check("pre_rst_full", 32'(inst_valid), 32'd1);
    cyc();
    reset = 1'b1; br_valid = 1'b1; br_target = 32'h300;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", 32'(inst_valid), 32'd0);
    check("mid_rst_req", 32'(imem_req), 32'd0);
    check("mid_rst_taken", 32'(redirect_taken), 32'd0);
    cyc(); reset = 1'b0; br_valid = 1'b0; inst_ready = 1'b1;
    push_range(32'd0, 3);
    @(negedge clk);
    check("restart_addr", imem_addr, 32'd0);
    check("restart_req", 32'(imem_req), 32'd1);
    check("restart_taken", 32'(redirect_taken), 32'd0);
    check("restart_no_stale", 32'(inst_valid), 32'd0);
    cyc(); @(negedge clk);
    check("restart_c1_valid", 32'(inst_valid), 32'd0);
    repeat (3) cyc();
    @(negedge clk);
    cyc(); inst_ready = 1'b0;
    check("t6_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor of the single-register PC fetch stage.
- Generates the PC with prioritised redirects (reset, interrupt vector, return, branch/call) and issues requests to a 1-cycle-latency synchronous instruction memory.
- Buffers fetched words in a DEPTH-entry queue, each tagged with its PC, and hands them to decode over a valid/ready handshake.
- Redirects flush the queue and any stale in-flight word, so decode never sees a wrong-path instruction.

Parameters:
- PC_W, 32, PC and address width.
- INST_W, 16, instruction word width.
- DEPTH, 4, fetch queue entries (power of two, >=2).
- IVT_ENTRIES, 8, interrupt vector count; IDX_W = clog2(IVT_ENTRIES).
- IVT_STRIDE, 2, words between vector slots.
- RESET_VEC, 0, PC loaded on reset.
- RET_MASK, 4, top bits of ret_pc forced to 0 (they carry saved flags).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  freeze request issue; the queue still drains.
- int_req  in  1  interrupt redirect.
- int_index  in  IDX_W  vector index.
- ivt_base  in  PC_W  vector table base.
- ret_valid  in  1  return redirect.
- ret_pc  in  PC_W  return address.
- br_valid  in  1  branch/call redirect.
- br_target  in  PC_W  branch/call target.
- imem_req  out  1  read request this cycle.
- imem_addr  out  PC_W  read address.
- imem_rdata  in  INST_W  data, valid exactly 1 cycle after imem_req.
- inst_valid  out  1  queue head valid.
- inst_data  out  INST_W  head instruction.
- inst_pc  out  PC_W  head PC.
- inst_ready  in  1  decode accepts head.
- redirect_taken  out  1  registered, 1 cycle after any redirect is applied.

Behaviour:
Reset:
- fetch_pc = RESET_VEC; queue empty; in-flight cleared.
- imem_req = 0, inst_valid = 0, redirect_taken = 0 for the whole reset cycle.
- First request is in the cycle after reset deasserts, with imem_addr = RESET_VEC.
- Reset in the middle of any operation discards everything, identically.

Redirect priority (combinational select, applied at the clock edge):
- int_req > ret_valid > br_valid > sequential.
- int target = ivt_base + int_index*IVT_STRIDE, truncated to PC_W (wraps).
- ret target = {RET_MASK zeros, ret_pc[PC_W-RET_MASK-1:0]}.
- br target = br_target.
- On a redirect in cycle N:
  - fetch_pc <= target.
  - Queue is flushed.
  - A word returning in N+1 from a cycle-N-or-earlier request is dropped (in-flight kill bit).
  - imem_req is 0 in cycle N.
  - In N+1, imem_addr = target and redirect_taken = 1.
- A head handshake completing in cycle N (inst_valid & inst_ready) counts as consumed; flushing does not undo it.

Issue rule:
- imem_req = !reset & !hold & !redirect & (count + inflight < DEPTH).
- inflight is 0 or 1, since latency is fixed at 1.
- On issue, fetch_pc <= fetch_pc + 1 (mod 2^PC_W; wraps from all-ones to 0).
- When not issuing, fetch_pc holds.
- Full throughput: one request per cycle while inst_ready stays 1.

Queue:
- A response is pushed the cycle it returns, tagged with the PC captured at request time.
- Pop on inst_valid & inst_ready.
- Simultaneous push and pop when full is legal and count is unchanged; the issue rule guarantees no overflow.
- Pop when empty is ignored.
- inst_valid = count != 0; outputs come straight from the head entry (no extra latency).
- Fetch-to-decode latency from request: 2 cycles minimum (cycle N request, N+1 push, visible at N+1 after the edge).

hold:
- Stops new requests only.
- An in-flight word still lands in the queue.
- A redirect during hold still updates fetch_pc and flushes.

Decomposition:
- Package fetch_pkg holds:
  - the redirect-source enum: SRC_SEQ, SRC_BR, SRC_RET, SRC_INT, SRC_RST;
  - the default constants PC_W_DEF, INST_W_DEF;
  - the function ivt_target(base, idx, stride).
- One sub-module, fetch_queue: a parametrised FIFO (WIDTH = INST_W+PC_W, DEPTH) with push, pop, synchronous flush, count output, and head data.
- fetch_unit contains the PC register, priority mux, in-flight kill bit, and issue logic.

Test Plan:
- Reset then run, inst_ready = 1, memory returns data = addr[15:0] -> inst_pc sequence 0,1,2,3… with inst_data equal to inst_pc, one word per cycle from the 2nd cycle after reset.
- inst_ready = 0 for 10 cycles with DEPTH = 4 -> exactly 4 entries (PCs 0..3) held, imem_req drops to 0, no overwrite; releasing ready yields 0..3 in order, then 4.
- br_valid = 1 with br_target = 0x100 while the queue holds 3 words and 1 is in flight -> queue empty and stale word dropped in N+1, imem_addr = 0x100, redirect_taken = 1, next inst_pc = 0x100.
- int_req, ret_valid and br_valid in the same cycle, with ivt_base = 0x20, int_index = 5, stride 2 -> target 0x2A; then ret_valid alone with ret_pc = 0xF0001234 -> target 0x00001234.
- fetch_pc reaches 0xFFFFFFFF -> the next request is at address 0x00000000.
- reset asserted mid-stream with a full queue -> inst_valid = 0 and imem_req = 0 that cycle; restart from RESET_VEC with no stale word delivered.
